jpu_uart_rx: RTL
================

JPU_UART_RX -- requirements
Module: jpu_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 Port clk  input  1  single core clock; all logic on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port uart_txd_in  input  1  asynchronous serial line from host, idle high.
REQ-005 Port rx_data  output  8  received byte, stable while rx_valid high.
REQ-006 Port rx_valid  output  1  byte available.
REQ-007 Port rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready.
REQ-008 Port rx_busy  output  1  high whenever FSM not in IDLE.
REQ-009 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port overrun_err  output  1  one-cycle pulse: byte completed while previous byte unaccepted.
REQ-011 Port parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 without JPU_UART_RX_PARITY_EN.

Function
REQ-012 uart_txd_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use; 2-cycle input latency.
REQ-013 FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-014 IDLE: synchronized line 0 -> START, bit counter cleared.
REQ-015 START: at count CLKS_PER_BIT/2-1 sample line; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no error).
REQ-016 DATA: sample at count CLKS_PER_BIT-1; shift in LSB first; 3-bit index 0..7; after bit 7 -> PARITY if enabled, else STOP.
REQ-017 STOP: sample at count CLKS_PER_BIT-1; 1 -> byte delivered, IDLE; 0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until synchronized line 1, then IDLE (break condition never restarts reception).
REQ-019 Delivery: rx_data loaded, rx_valid set the cycle after stop-bit sample; held until handshake.
REQ-020 Handshake: rx_valid cleared cycle after rx_valid&&rx_ready, unless new byte delivered same cycle.
REQ-021 New byte while rx_valid&&!rx_ready: overrun_err pulse, new byte dropped, old rx_data retained.
REQ-022 New byte in same cycle as handshake: new byte loaded, rx_valid stays high, no overrun.
REQ-023 Counter width $clog2(CLKS_PER_BIT); never exceeds CLKS_PER_BIT-1; wraps to 0 at each sample.
REQ-024 Error pulses and delivery independent: parity_err byte still delivered unless overrun.

Reset
REQ-025 rst SHALL force: FSM IDLE, counters 0, synchronizer 1, rx_data 0x00, rx_valid 0, rx_busy 0, all error pulses 0.
REQ-026 Reset mid-frame SHALL abandon the partial byte; reception resumes on the next falling edge after reset release.

Configuration
REQ-027 Macro JPU_UART_RX_PARITY_EN defined: even-parity bit sampled in PARITY state after bit 7; mismatch -> parity_err pulse at stop sample.
REQ-028 Macro undefined: PARITY state absent, 8N1 framing, parity_err constant 0.

Structure
REQ-029 Package jpu_uart_pkg SHALL hold the FSM state typedef, UART_DATA_BITS=8 and default CLKS_PER_BIT constant, shared with the existing transmitter.
REQ-030 One sub-module jpu_sync2 (2-flop synchronizer, parameterized reset value); everything else inline.

Verification (CLKS_PER_BIT=16)
REQ-031 Send 0xA5 8N1, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, no errors.
REQ-032 Low pulse of 5 cycles on idle line -> return to IDLE, no rx_valid, no errors.
REQ-033 Send 0x3C with stop bit 0, line held low 40 cycles -> frame_err one pulse, no rx_valid, FSM in WAIT_HIGH until line high.
REQ-034 rx_ready=0, send 0x11 then 0x22 -> rx_valid high with 0x11, overrun_err one pulse, rx_data still 0x11.
REQ-035 rx_ready asserted exactly on 0x22 delivery cycle -> 0x11 accepted, rx_data=0x22, rx_valid stays high, no overrun.
REQ-036 Assert rst during bit 4 of 0xFF, then send 0x5A -> all outputs reset values, then rx_data=0x5A; with macro, 0x5A wrong parity -> parity_err pulse.

Source files
------------

// File: rtl/jpu_uart_pkg.sv
// jpu_uart_pkg: UART types and constants shared by the receiver and the transmitter.
// Optional macro JPU_UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package jpu_uart_pkg;

  localparam int unsigned UART_DATA_BITS        = 8;
  localparam int unsigned UART_CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef JPU_UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } uart_rx_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity_bit(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/jpu_sync2.sv
// jpu_sync2: two-flop synchronizer for a single asynchronous bit, with a
// parameterized reset value so an idle-high line reads as idle out of reset.
module jpu_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/jpu_uart_rx.sv
// jpu_uart_rx: oversampled UART receiver (8N1) with a valid/ready byte output
// and one-cycle framing, overrun and parity error pulses.
// Optional macro JPU_UART_RX_PARITY_EN: an even-parity bit follows data bit 7.
module jpu_uart_rx
  import jpu_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uart_txd_in,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_busy,
  output logic                      frame_err,
  output logic                      overrun_err,
  output logic                      parity_err
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'd7;

  logic line_s;

  uart_rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      deliver_s;
  logic                      frame_err_s;

  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      rx_busy_q;
  logic                      frame_err_q;
  logic                      overrun_err_q;

`ifdef JPU_UART_RX_PARITY_EN
  logic parity_bit_q, parity_bit_d;
  logic parity_err_s;
  logic parity_err_q;
`endif

  jpu_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (uart_txd_in),
    .q_o (line_s)
  );

  // Frame state, bit-period counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
`ifdef JPU_UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef JPU_UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
`endif
    end
  end

  // Next-state logic: every bit is sampled once, at the end of its counted
  // period; the start bit is re-checked at mid-bit to reject line glitches.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver_s   = 1'b0;
    frame_err_s = 1'b0;
`ifdef JPU_UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_s = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d     = CNT_ZERO;
        bit_idx_d = 3'd0;
        if (!line_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = CNT_ZERO;
          if (!line_s) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = CNT_ZERO;
          shift_d   = {line_s, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == BIT_LAST) begin
`ifdef JPU_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef JPU_UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = CNT_ZERO;
          parity_bit_d = line_s;
          state_d      = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
`ifdef JPU_UART_RX_PARITY_EN
          parity_err_s = (parity_bit_q != even_parity_bit(shift_q));
`endif
          if (line_s) begin
            deliver_s = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low (break) line must not be mistaken for a new start bit.
        if (line_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = CNT_ZERO;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Output holding register, handshake, busy flag and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_busy_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rx_busy_q     <= (state_d != S_IDLE);
      frame_err_q   <= frame_err_s;
      overrun_err_q <= deliver_s && rx_valid_q && !rx_ready;
      if (deliver_s && (!rx_valid_q || rx_ready)) begin
        // Slot empty, or being emptied this very cycle: take the new byte.
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end else begin
        rx_valid_q <= rx_valid_q;
      end
    end
  end

`ifdef JPU_UART_RX_PARITY_EN
  // Parity error pulse, aligned with the other error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_s;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = rx_busy_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule
